router_mesh_param: RTL and testbench

- Parametrised 5-port mesh router: LOCAL, EAST, WEST, NORTH, SOUTH.
- One generic block serves corner, border and interior nodes of the mesh. Unused ports are removed through a port-enable mask.
- Single-flit packets. Dimension-ordered XY routing. Per-output round-robin arbitration. Per-input FIFO buffering. Valid/full backpressure on every link.
- Instantiated once per node in the NoC top level.

---
 rtl/router_mesh_param.sv | 183 ++++++++++++++++++
 tb/tb_router_mesh_param.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_mesh_param.sv
// rtl/router_mesh_param.sv - 5-port XY mesh router with per-input FWFT FIFOs and per-output round-robin
// Port order: 0=LOCAL 1=EAST 2=WEST 3=NORTH 4=SOUTH; disabled ports are masked by PORT_EN.

module router_mesh_param_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        wdata,
  output logic [WIDTH-1:0]        rdata,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Caller guarantees push only when not full and pop only when not empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
endmodule

module router_mesh_param #(
  parameter int           DATA_WIDTH = 32,
  parameter int           FIFO_DEPTH = 8,
  parameter int           X_BITS     = 1,
  parameter int           Y_BITS     = 2,
  parameter int           X_ADDR     = 0,
  parameter int           Y_ADDR     = 0,
  parameter logic [4:0]   PORT_EN    = 5'b11111
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [5*DATA_WIDTH-1:0]   DATA_IN,
  input  logic [4:0]                DATA_VALID_IN,
  output logic [4:0]                FULL_OUT,
  output logic [5*DATA_WIDTH-1:0]   DATA_OUT,
  output logic [4:0]                DATA_VALID_OUT,
  input  logic [4:0]                FULL_IN,
  output logic [4:0]                DROP_ERR
);
  localparam int                NP = 5;
  localparam int                CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [X_BITS-1:0] XA = X_BITS'(X_ADDR);
  localparam logic [Y_BITS-1:0] YA = Y_BITS'(Y_ADDR);
  localparam logic [NP-1:0]     EN = PORT_EN;

  localparam logic [2:0] P_LOCAL = 3'd0;
  localparam logic [2:0] P_EAST  = 3'd1;
  localparam logic [2:0] P_WEST  = 3'd2;
  localparam logic [2:0] P_NORTH = 3'd3;
  localparam logic [2:0] P_SOUTH = 3'd4;

  logic [DATA_WIDTH-1:0] head [NP];
  logic [CW-1:0]         count [NP];
  logic [2:0]            route [NP];
  logic [NP-1:0]         nonempty;
  logic [NP-1:0]         full;
  logic [NP-1:0]         push;
  logic [NP-1:0]         pop;
  logic [NP-1:0]         ovf;
  logic [NP-1:0]         route_drop;

  logic [DATA_WIDTH-1:0] data_q [NP];
  logic [NP-1:0]         valid_q;
  logic [NP-1:0]         drop_q;
  logic [2:0]            rr_ptr [NP];
  logic [NP-1:0]         out_free;
  logic [NP-1:0]         grant_valid;
  logic [2:0]            grant_idx [NP];

  for (genvar i = 0; i < NP; i++) begin : g_port
    logic [X_BITS-1:0] dx;
    logic [Y_BITS-1:0] dy;

    // Full is judged on the registered count, so a same-cycle pop never makes room.
    assign full[i]     = (count[i] == CW'(FIFO_DEPTH));
    assign nonempty[i] = (count[i] != '0);
    assign push[i]     = EN[i] & DATA_VALID_IN[i] & ~full[i];
    assign ovf[i]      = EN[i] & DATA_VALID_IN[i] &  full[i];
    assign FULL_OUT[i] = EN[i] ? full[i] : 1'b1;

    router_mesh_param_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[i]),
      .pop   (pop[i]),
      .wdata (DATA_IN[i*DATA_WIDTH +: DATA_WIDTH]),
      .rdata (head[i]),
      .count (count[i])
    );

    assign dx = head[i][X_BITS-1:0];
    assign dy = head[i][X_BITS+Y_BITS-1:X_BITS];
    assign route[i] = (dx > XA) ? P_EAST  :
                      (dx < XA) ? P_WEST  :
                      (dy > YA) ? P_SOUTH :
                      (dy < YA) ? P_NORTH : P_LOCAL;
    assign route_drop[i] = nonempty[i] & ~EN[route[i]];

    assign out_free[i] = ~valid_q[i] | ~FULL_IN[i];
    assign DATA_OUT[i*DATA_WIDTH +: DATA_WIDTH] = data_q[i];
  end

  assign DATA_VALID_OUT = valid_q;
  assign DROP_ERR       = drop_q;

  // Each input requests exactly one output, so per-output arbiters never collide on a pop.
  always_comb begin
    int   idx;
    logic found;
    idx         = 0;
    found       = 1'b0;
    grant_valid = '0;
    pop         = route_drop;
    for (int j = 0; j < NP; j++) begin
      grant_idx[j] = '0;
    end
    for (int j = 0; j < NP; j++) begin
      found = 1'b0;
      if (EN[j] && out_free[j]) begin
        for (int k = 0; k < NP; k++) begin
          idx = (int'(rr_ptr[j]) + k) % NP;
          if (!found && nonempty[idx] && (route[idx] == 3'(j))) begin
            found          = 1'b1;
            grant_valid[j] = 1'b1;
            grant_idx[j]   = 3'(idx);
            pop[idx]       = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      drop_q  <= '0;
      for (int j = 0; j < NP; j++) begin
        data_q[j] <= '0;
        rr_ptr[j] <= '0;
      end
    end else begin
      drop_q <= drop_q | ovf | route_drop;
      for (int j = 0; j < NP; j++) begin
        if (grant_valid[j]) begin
          data_q[j]  <= head[grant_idx[j]];
          valid_q[j] <= 1'b1;
          rr_ptr[j]  <= (grant_idx[j] == 3'd4) ? 3'd0 : grant_idx[j] + 3'd1;
        end else if (out_free[j]) begin
          data_q[j]  <= '0;
          valid_q[j] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_router_mesh_param.sv
// tb/tb_router_mesh_param.sv - scoreboard bench for router_mesh_param at node (0,1)
module tb_router_mesh_param;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [159:0] din = '0;
  logic [4:0]   vin = '0;
  logic [4:0]   full_out;
  logic [159:0] dout;
  logic [4:0]   vout;
  logic [4:0]   full_in = '0;
  logic [4:0]   drop;

  logic [159:0] d2_din = '0;
  logic [4:0]   d2_vin = '0;
  logic [4:0]   d2_full_out;
  logic [159:0] d2_dout;
  logic [4:0]   d2_vout;
  logic [4:0]   d2_drop;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] q0[$], q1[$], q2[$], q3[$], q4[$];

  always #5 clk = ~clk;

  router_mesh_param #(
    .DATA_WIDTH(32), .FIFO_DEPTH(8), .X_BITS(1), .Y_BITS(2),
    .X_ADDR(0), .Y_ADDR(1), .PORT_EN(5'b11011)
  ) dut (
    .clk(clk), .rst_n(rst_n), .DATA_IN(din), .DATA_VALID_IN(vin),
    .FULL_OUT(full_out), .DATA_OUT(dout), .DATA_VALID_OUT(vout),
    .FULL_IN(full_in), .DROP_ERR(drop)
  );

  router_mesh_param #(
    .DATA_WIDTH(32), .FIFO_DEPTH(8), .X_BITS(1), .Y_BITS(2),
    .X_ADDR(0), .Y_ADDR(1), .PORT_EN(5'b10111)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .DATA_IN(d2_din), .DATA_VALID_IN(d2_vin),
    .FULL_OUT(d2_full_out), .DATA_OUT(d2_dout), .DATA_VALID_OUT(d2_vout),
    .FULL_IN(5'b00000), .DROP_ERR(d2_drop)
  );

  task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int tag, input logic [2:0] dest);
    logic [28:0] t;
    t = 29'(tag);
    return {t, dest};
  endfunction

  function automatic int sb_size(input int p);
    case (p)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      3: return q3.size();
      default: return q4.size();
    endcase
  endfunction

  function automatic void sb_push(input int p, input logic [31:0] v);
    case (p)
      0: q0.push_back(v);
      1: q1.push_back(v);
      2: q2.push_back(v);
      3: q3.push_back(v);
      default: q4.push_back(v);
    endcase
  endfunction

  function automatic logic [31:0] sb_pop(input int p);
    case (p)
      0: return q0.pop_front();
      1: return q1.pop_front();
      2: return q2.pop_front();
      3: return q3.pop_front();
      default: return q4.pop_front();
    endcase
  endfunction

  // Monitor: a flit is consumed on the coming edge when valid and not backpressured.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int j = 0; j < 5; j++) begin
        if (vout[j] && !full_in[j]) begin
          if (sb_size(j) == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL unexpected_flit port %0d: got %0h expected none", j, dout[j*32 +: 32]);
          end else begin
            check($sformatf("sb_port%0d", j), 160'(dout[j*32 +: 32]), 160'(sb_pop(j)));
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic [31:0] f);
    din[p*32 +: 32] = f;
    vin[p] = 1'b1;
  endtask

  task automatic drain(input string name, input int p);
    int n;
    n = 0;
    while (sb_size(p) != 0 && n < 60) begin
      step();
      n++;
    end
    check(name, 160'(sb_size(p)), 160'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] f;
    logic [4:0]  acc;
    int          ones, run, max_run;
    logic [2:0]  dests [4];
    int          ports [4];
    dests[0] = 3'b011; ports[0] = 1;
    dests[1] = 3'b000; ports[1] = 3;
    dests[2] = 3'b110; ports[2] = 4;
    dests[3] = 3'b010; ports[3] = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_vout", 160'(vout), 160'd0);
    check("rst_drop", 160'(drop), 160'd0);
    check("rst_full_out", 160'(full_out), 160'(5'b00100));
    check("rst_dout", dout, 160'd0);
    check("rst_full_out_d2", 160'(d2_full_out), 160'(5'b01000));
    rst_n = 1'b1;
    step();
    check("post_rst_full_out", 160'(full_out), 160'(5'b00100));

    // Routing and latency from LOCAL
    for (int v = 0; v < 4; v++) begin
      f = mk(100 + v, dests[v]);
      drive(0, f);
      sb_push(ports[v], f);
      step();
      vin = '0;
      check($sformatf("lat_early_%0d", v), 160'(vout), 160'd0);
      step();
      check($sformatf("route_%0d", v), 160'(vout), 160'(5'b00001 << ports[v]));
      step();
    end

    // Disabled WEST input is ignored
    drive(2, mk(7, 3'b010));
    step();
    vin = '0;
    step();
    check("west_off_drop", 160'(drop[2]), 160'd0);
    check("west_off_full", 160'(full_out[2]), 160'd1);
    check("west_off_vout", 160'(vout), 160'd0);

    // Reset with flits buffered behind a stalled EAST output
    full_in[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(0, mk(200 + k, 3'b001));
      step();
    end
    vin = '0;
    step();
    step();
    rst_n = 1'b0;
    step();
    check("midrst_vout", 160'(vout), 160'd0);
    rst_n = 1'b1;
    full_in = '0;
    acc = '0;
    for (int k = 0; k < 10; k++) begin
      step();
      acc = acc | vout;
    end
    check("midrst_no_flit", 160'(acc), 160'd0);

    // Round robin on EAST: LOCAL, NORTH, SOUTH each send 4
    ones = 0; run = 0; max_run = 0;
    for (int c = 0; c < 20; c++) begin
      vin = '0;
      if (c < 4) begin
        drive(0, mk(300 + c, 3'b001));
        drive(3, mk(400 + c, 3'b001));
        drive(4, mk(500 + c, 3'b001));
        sb_push(1, mk(300 + c, 3'b001));
        sb_push(1, mk(400 + c, 3'b001));
        sb_push(1, mk(500 + c, 3'b001));
      end
      step();
      if (vout[1]) begin
        ones++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
    end
    vin = '0;
    check("rr_valid_cycles", 160'(ones), 160'd12);
    check("rr_consecutive", 160'(max_run), 160'd12);
    drain("rr_drain", 1);

    // Backpressure: EAST held full while LOCAL streams 12 flits
    full_in[1] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      drive(0, mk(600 + k, 3'b001));
      if (k <= 9) sb_push(1, mk(600 + k, 3'b001));
      step();
      if (k >= 2) begin
        check($sformatf("hold_dout_%0d", k), 160'(dout[63:32]), 160'(mk(601, 3'b001)));
        check($sformatf("hold_vout_%0d", k), 160'(vout[1]), 160'd1);
      end
      if (k == 8) check("full_after8", 160'(full_out[0]), 160'd0);
      if (k == 9) check("full_after9", 160'(full_out[0]), 160'd1);
      if (k == 9) check("drop_after9", 160'(drop[0]), 160'd0);
      if (k == 10) check("drop_after10", 160'(drop[0]), 160'd1);
    end
    // Release and push into the full FIFO on the same edge: rejected, count drops to 7
    full_in[1] = 1'b0;
    drive(0, mk(613, 3'b001));
    step();
    vin = '0;
    check("full_pop_push_count7", 160'(full_out[0]), 160'd0);
    drain("hold_drain", 1);

    // Pointer wrap: stream 20 flits
    for (int k = 0; k < 20; k++) begin
      drive(0, mk(700 + k, 3'b001));
      sb_push(1, mk(700 + k, 3'b001));
      step();
    end
    vin = '0;
    drain("wrap_drain", 1);
    check("drop_sticky", 160'(drop), 160'(5'b00001));

    // NORTH disabled node: route to NORTH is dropped
    d2_din[31:0] = mk(800, 3'b000);
    d2_vin[0] = 1'b1;
    step();
    d2_vin = '0;
    check("d2_drop_early", 160'(d2_drop[0]), 160'd0);
    check("d2_vout_early", 160'(d2_vout), 160'd0);
    step();
    check("d2_drop_set", 160'(d2_drop[0]), 160'd1);
    check("d2_vout_none", 160'(d2_vout), 160'd0);
    d2_din[31:0] = mk(801, 3'b010);
    d2_vin[0] = 1'b1;
    step();
    d2_vin = '0;
    step();
    check("d2_drained_vout", 160'(d2_vout), 160'(5'b00001));
    check("d2_drained_dout", 160'(d2_dout[31:0]), 160'(mk(801, 3'b010)));

    for (int j = 0; j < 5; j++) begin
      check($sformatf("sb_empty_%0d", j), 160'(sb_size(j)), 160'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
